clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
- Programmable clock divider generating the sample/strobe clock for the ADC and servo-PWM paths.
- Successor to the fixed 18-bit toggle divider: parametrised width and reset divisor.
- Adds a glitch-free runtime divisor reload (shadow register, applied at half-period boundaries) and single-cycle rise/fall strobes for synchronous consumers.
- Sits between the system clock and the ADC/servo controllers.

Parameters:
- WIDTH, 18, width of the counter and the divisor.
- DEFAULT_HALF, 249999, half-period minus 1 loaded at reset (clk_out period = 2*(half+1) clk_in cycles).
- BURST_W, 8, width of the burst edge counter (used only with CLKDIV_BURST_EN).

Ports:
- clk_in  in  1  system clock, all logic on its rising edge.
- clk_rst  in  1  asynchronous reset, active-high.
- enable  in  1  1 = run divider; 0 = hold idle.
- load  in  1  single-cycle request to take half_period as the new divisor.
- half_period  in  WIDTH  new half-period minus 1; sampled only when load=1.
- clk_out  out  1  divided clock, registered.
- tick_rise  out  1  one-cycle pulse, high in the same cycle clk_out goes 0->1.
- tick_fall  out  1  one-cycle pulse, high in the same cycle clk_out goes 1->0.
- load_pending  out  1  shadow divisor waiting for a boundary.
- burst_len  in  BURST_W  rising edges per burst; 0 = continuous (macro only).
- burst_done  out  1  burst finished (macro only).

Behaviour:
- Reset (clk_rst asynchronous, active-high; clock clk_in): counter=0, half_reg=DEFAULT_HALF, shadow=0, clk_out=0, tick_rise=0, tick_fall=0, load_pending=0, burst_done=0.
- Two states, IDLE (enable=0) and RUN (enable=1); the state is enable registered implicitly.
- IDLE:
  - counter<=0, clk_out<=0, tick_rise/tick_fall<=0.
  - load, or an already pending shadow, writes half_reg on the next edge and clears load_pending.
  - Leaving RUN with clk_out=1 drops clk_out with no tick_fall.
- RUN:
  - counter increments each cycle. Terminal is counter==half_reg.
  - At terminal: counter<=0, clk_out<=~clk_out, tick_rise<=~clk_out, tick_fall<=clk_out.
  - First rising edge after enable 0->1 occurs half_reg+1 cycles later.
- Reload in RUN:
  - load with no terminal: shadow<=half_period, load_pending<=1. A second load before the boundary overwrites shadow (last wins).
  - At terminal with load_pending=1: half_reg<=shadow, load_pending<=0. The new value governs the next half-period.
  - load in the same cycle as terminal: half_period goes straight to half_reg (bypass), load_pending<=0.
- half_reg=0 is legal: clk_out toggles every cycle (divide by 2), and tick_rise/tick_fall alternate every cycle.
- Counter never exceeds half_reg. If a reload shrinks the divisor, it takes effect only after the counter has wrapped to 0, so no overrun or wrap-around past 2^WIDTH-1.
- Strobes are registered and never asserted together.
- clk_rst mid-period discards the count and any pending shadow.

Optional Feature:
- Macro CLKDIV_BURST_EN.
- Defined:
  - burst_len and burst_done ports exist, plus a BURST_W edge counter cleared on enable 0->1.
  - Each tick_rise increments the counter. When the count reaches burst_len (nonzero), the following terminal (falling edge) ends the burst: clk_out stays 0, counter held at 0, burst_done=1 until enable drops.
  - burst_len=0 gives continuous running.
  - burst_len is sampled on enable 0->1.
- Not defined: ports absent, divider always continuous, no burst logic synthesised.

Test Plan:
- Reset default: DEFAULT_HALF=3, enable=1 after reset -> first tick_rise 4 cycles after enable; clk_out period 8 cycles, 50% duty; tick_rise/tick_fall pulses 4 cycles apart.
- Reload mid-period: half_reg=3, load with half_period=1 at counter=1 -> load_pending=1 until the next terminal, then half-periods of 2 cycles; no short or glitch pulse.
- Simultaneous load and terminal: load half_period=5 on the terminal cycle -> load_pending stays 0; next half-period is 6 cycles.
- Divide by 2: half_period=0 loaded in IDLE, enable=1 -> clk_out toggles every cycle; tick_rise and tick_fall alternate every cycle.
- Disable and reset mid-operation: enable=0 while clk_out=1 -> clk_out=0 next cycle with no tick_fall. clk_rst pulse with load_pending=1 -> half_reg=DEFAULT_HALF, pending cleared.
- Burst (CLKDIV_BURST_EN): burst_len=3, half=2 -> exactly 3 tick_rise, then burst_done=1 and clk_out=0 held; toggling enable restarts the burst.

Source files
------------

// File: rtl/clk_div_prog.sv
// ---------------------------------------------------------------------------
// clk_div_prog -- programmable clock divider for the ADC / servo-PWM paths.
//
// Produces a registered divided clock whose half-period is (half_reg+1)
// clk_in cycles. A new divisor can be loaded at run time without glitching.
// The new value waits in a shadow register until the next half-period
// boundary. Single-cycle rise/fall strobes are provided for synchronous
// consumers.
//
// Optional build macro: CLKDIV_BURST_EN adds burst mode (burst_len/burst_done).
//
// Ports
//   clk_in        in   system clock, rising edge
//   clk_rst       in   asynchronous reset, active-high
//   enable        in   1 = run divider, 0 = hold idle
//   load          in   one-cycle request to take half_period as new divisor
//   half_period   in   new half-period minus 1 (WIDTH bits)
//   clk_out       out  divided clock, registered
//   tick_rise     out  one-cycle pulse coincident with clk_out 0->1
//   tick_fall     out  one-cycle pulse coincident with clk_out 1->0
//   load_pending  out  shadow divisor waiting for a boundary
//   burst_len     in   rising edges per burst, 0 = continuous (macro only)
//   burst_done    out  burst finished, held until enable drops (macro only)
//
// State table
//   state   | meaning
//   ST_IDLE | enable was low last cycle; counter and clk_out held at 0
//   ST_RUN  | dividing; counter runs and clk_out toggles at terminal
//   ST_DONE | burst complete; clk_out parked low until enable drops
// ---------------------------------------------------------------------------
module clk_div_prog #(
   parameter int WIDTH        = 18,
   parameter int DEFAULT_HALF = 249999,
   parameter int BURST_W      = 8
) (
   input  logic             clk_in,
   input  logic             clk_rst,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] half_period,
   output logic             clk_out,
   output logic             tick_rise,
   output logic             tick_fall,
   output logic             load_pending
`ifdef CLKDIV_BURST_EN
   ,
   input  logic [BURST_W-1:0] burst_len,
   output logic               burst_done
`endif
);

   localparam logic [WIDTH-1:0] HALF_RST = WIDTH'(DEFAULT_HALF);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] cnt_q,    cnt_d;
   logic [WIDTH-1:0] half_q,   half_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             pend_q,   pend_d;
   logic             clk_q,    clk_d;
   logic             rise_q,   rise_d;
   logic             fall_q,   fall_d;

   logic             terminal;
   logic             reload_en;
   logic [WIDTH-1:0] reload_val;

`ifdef CLKDIV_BURST_EN
   logic [BURST_W-1:0] bcnt_q, bcnt_d;
   logic [BURST_W-1:0] blen_q, blen_d;
   logic [BURST_W-1:0] bcnt_base;
   logic               start;
`endif

   assign terminal   = (cnt_q == half_q);
   // A load arriving on a boundary beats any older shadow value.
   assign reload_en  = load | pend_q;
   assign reload_val = load ? half_period : shadow_q;

   always_ff @(posedge clk_in or posedge clk_rst) begin
      if (clk_rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         half_q   <= HALF_RST;
         shadow_q <= '0;
         pend_q   <= 1'b0;
         clk_q    <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
`ifdef CLKDIV_BURST_EN
         bcnt_q   <= '0;
         blen_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         half_q   <= half_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         clk_q    <= clk_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
`ifdef CLKDIV_BURST_EN
         bcnt_q   <= bcnt_d;
         blen_q   <= blen_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      half_d   = half_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      clk_d    = clk_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
`ifdef CLKDIV_BURST_EN
      start     = (state_q == ST_IDLE);
      bcnt_base = start ? '0 : bcnt_q;
      bcnt_d    = bcnt_q;
      blen_d    = start ? burst_len : blen_q;
`endif

      if (!enable || state_q == ST_DONE) begin
         // Not dividing: park the output low (no strobe) and apply any
         // divisor request immediately since there is no period to protect.
         state_d = enable ? ST_DONE : ST_IDLE;
         cnt_d   = '0;
         clk_d   = 1'b0;
         if (reload_en) begin
            half_d = reload_val;
            pend_d = 1'b0;
         end
      end else begin
         state_d = ST_RUN;
`ifdef CLKDIV_BURST_EN
         bcnt_d  = bcnt_base;
`endif
         if (terminal) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            rise_d = ~clk_q;
            fall_d = clk_q;
            // Divisor only changes when the counter wraps to 0, so a smaller
            // value can never leave the counter stranded above it.
            if (reload_en) begin
               half_d = reload_val;
               pend_d = 1'b0;
            end
`ifdef CLKDIV_BURST_EN
            if (!clk_q) begin
               bcnt_d = bcnt_base + 1'b1;
            end else if (blen_q != '0 && bcnt_q == blen_q) begin
               state_d = ST_DONE;
            end
`endif
         end else begin
            cnt_d = cnt_q + 1'b1;
            if (load) begin
               shadow_d = half_period;
               pend_d   = 1'b1;
            end
         end
      end
   end

   assign clk_out      = clk_q;
   assign tick_rise    = rise_q;
   assign tick_fall    = fall_q;
   assign load_pending = pend_q;
`ifdef CLKDIV_BURST_EN
   assign burst_done   = (state_q == ST_DONE);
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

   logic        clk_in = 1'b0;
   logic        clk_rst;
   logic        enable;
   logic        load;
   logic [17:0] half_period;
   logic        clk_out;
   logic        tick_rise;
   logic        tick_fall;
   logic        load_pending;
`ifdef CLKDIV_BURST_EN
   logic [7:0]  burst_len;
   logic        burst_done;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk_in = ~clk_in;

   clk_div_prog #(
      .WIDTH       (18),
      .DEFAULT_HALF(3),
      .BURST_W     (8)
   ) dut (
      .clk_in      (clk_in),
      .clk_rst     (clk_rst),
      .enable      (enable),
      .load        (load),
      .half_period (half_period),
      .clk_out     (clk_out),
      .tick_rise   (tick_rise),
      .tick_fall   (tick_fall),
      .load_pending(load_pending)
`ifdef CLKDIV_BURST_EN
      ,
      .burst_len   (burst_len),
      .burst_done  (burst_done)
`endif
   );

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // Steps until the requested strobe is seen; n = cycles taken (40 = timeout).
   task automatic wait_for(input bit rise, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!(rise ? tick_rise : tick_fall) && n < 40);
   endtask

   task automatic test_reset();
      clk_rst = 1'b1; enable = 1'b0; load = 1'b0; half_period = '0;
`ifdef CLKDIV_BURST_EN
      burst_len = '0;
`endif
      step(); step();
      checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL reset_clk_out got=%b exp=0", clk_out); end
      checks++; if (tick_rise !== 1'b0) begin failures++; $display("FAIL reset_tick_rise got=%b exp=0", tick_rise); end
      checks++; if (tick_fall !== 1'b0) begin failures++; $display("FAIL reset_tick_fall got=%b exp=0", tick_fall); end
      checks++; if (load_pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", load_pending); end
      clk_rst = 1'b0;
      step();
   endtask

   task automatic test_default();
      int n, hi, both;
      enable = 1'b1;
      wait_for(1'b1, n);
      checks++; if (n != 4) begin failures++; $display("FAIL default_first_rise got=%0d exp=4", n); end
      checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL default_clk_high got=%b exp=1", clk_out); end
      wait_for(1'b0, n);
      checks++; if (n != 4) begin failures++; $display("FAIL default_rise_to_fall got=%0d exp=4", n); end
      checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL default_clk_low got=%b exp=0", clk_out); end
      wait_for(1'b1, n);
      checks++; if (n != 4) begin failures++; $display("FAIL default_fall_to_rise got=%0d exp=4", n); end
      hi = 0; both = 0;
      for (int i = 0; i < 8; i++) begin
         if (clk_out === 1'b1) hi++;
         if (tick_rise === 1'b1 && tick_fall === 1'b1) both++;
         step();
      end
      checks++; if (hi != 4) begin failures++; $display("FAIL default_duty got=%0d exp=4", hi); end
      checks++; if (both != 0) begin failures++; $display("FAIL default_strobe_overlap got=%0d exp=0", both); end
   endtask

   task automatic test_reload_mid();
      int n;
      wait_for(1'b1, n);
      step();
      load = 1'b1; half_period = 18'd1;
      step();
      load = 1'b0;
      checks++; if (load_pending !== 1'b1) begin failures++; $display("FAIL reload_pending_set got=%b exp=1", load_pending); end
      checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL reload_no_glitch got=%b exp=1", clk_out); end
      step();
      checks++; if (load_pending !== 1'b1 || tick_fall !== 1'b0) begin failures++; $display("FAIL reload_hold got=%b%b exp=10", load_pending, tick_fall); end
      step();
      checks++; if (tick_fall !== 1'b1 || load_pending !== 1'b0) begin failures++; $display("FAIL reload_boundary got=%b%b exp=10", tick_fall, load_pending); end
      wait_for(1'b1, n);
      checks++; if (n != 2) begin failures++; $display("FAIL reload_new_half_rise got=%0d exp=2", n); end
      wait_for(1'b0, n);
      checks++; if (n != 2) begin failures++; $display("FAIL reload_new_half_fall got=%0d exp=2", n); end
   endtask

   task automatic test_simultaneous();
      int n;
      // Previous task ended on a fall with half=1: next terminal is 2 cycles out.
      step();
      load = 1'b1; half_period = 18'd5;
      step();
      load = 1'b0;
      checks++; if (tick_rise !== 1'b1) begin failures++; $display("FAIL simul_terminal got=%b exp=1", tick_rise); end
      checks++; if (load_pending !== 1'b0) begin failures++; $display("FAIL simul_pending got=%b exp=0", load_pending); end
      wait_for(1'b0, n);
      checks++; if (n != 6) begin failures++; $display("FAIL simul_half got=%0d exp=6", n); end
      wait_for(1'b1, n);
      checks++; if (n != 6) begin failures++; $display("FAIL simul_half2 got=%0d exp=6", n); end
   endtask

   task automatic test_div2();
      logic lvl;
      enable = 1'b0;
      step();
      load = 1'b1; half_period = '0;
      step();
      load = 1'b0;
      checks++; if (load_pending !== 1'b0 || clk_out !== 1'b0) begin failures++; $display("FAIL div2_idle got=%b%b exp=00", load_pending, clk_out); end
      enable = 1'b1;
      lvl = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         lvl = ~lvl;
         checks++;
         if (clk_out !== lvl || tick_rise !== lvl || tick_fall !== ~lvl) begin
            failures++;
            $display("FAIL div2_cycle%0d got=%b%b%b exp=%b%b%b", i, clk_out, tick_rise, tick_fall, lvl, lvl, ~lvl);
         end
      end
   endtask

   task automatic test_disable_reset();
      int n;
      enable = 1'b0;
      step();
      load = 1'b1; half_period = 18'd2;
      step();
      load = 1'b0; enable = 1'b1;
      wait_for(1'b1, n);
      checks++; if (n != 3) begin failures++; $display("FAIL dis_first_rise got=%0d exp=3", n); end
      enable = 1'b0;
      step();
      checks++; if (clk_out !== 1'b0 || tick_fall !== 1'b0) begin failures++; $display("FAIL dis_drop got=%b%b exp=00", clk_out, tick_fall); end
      load = 1'b1; half_period = 18'd20;
      step();
      load = 1'b0; enable = 1'b1;
      step(); step();
      load = 1'b1; half_period = 18'd7;
      step();
      load = 1'b0;
      checks++; if (load_pending !== 1'b1) begin failures++; $display("FAIL rst_pending_before got=%b exp=1", load_pending); end
      clk_rst = 1'b1;
      #1;
      checks++; if (load_pending !== 1'b0 || clk_out !== 1'b0) begin failures++; $display("FAIL rst_async got=%b%b exp=00", load_pending, clk_out); end
      step();
      clk_rst = 1'b0;
      wait_for(1'b1, n);
      checks++; if (n != 4) begin failures++; $display("FAIL rst_default_rise got=%0d exp=4", n); end
      wait_for(1'b0, n);
      checks++; if (n != 4) begin failures++; $display("FAIL rst_default_fall got=%0d exp=4", n); end
      enable = 1'b0;
      step();
   endtask

   // Reference: each half-period lasts (h+1) cycles, where h is the last value
   // loaded during the previous half-period (its closing boundary included).
   task automatic test_random();
      int cur, latest, next_edge;
      bit have_new, lvl, ld, er, ef;
      int v;
      enable = 1'b0;
      step();
      cur = $urandom_range(0, 5);
      load = 1'b1; half_period = 18'(cur);
      step();
      load = 1'b0; enable = 1'b1;
      lvl = 1'b0; have_new = 1'b0; latest = 0;
      next_edge = cur + 1;
      for (int n = 1; n <= 400; n++) begin
         ld = ($urandom_range(0, 5) == 0);
         v  = $urandom_range(0, 6);
         load = ld; half_period = 18'(v);
         step();
         if (ld) begin latest = v; have_new = 1'b1; end
         er = 1'b0; ef = 1'b0;
         if (n == next_edge) begin
            lvl = ~lvl;
            er  = lvl;
            ef  = ~lvl;
            if (have_new) begin cur = latest; have_new = 1'b0; end
            next_edge = n + cur + 1;
         end
         checks++;
         if (clk_out !== lvl || tick_rise !== er || tick_fall !== ef || load_pending !== have_new) begin
            failures++;
            $display("FAIL random_cycle%0d got=%b%b%b%b exp=%b%b%b%b", n, clk_out, tick_rise, tick_fall, load_pending, lvl, er, ef, have_new);
         end
      end
      load = 1'b0; enable = 1'b0;
      step();
   endtask

`ifdef CLKDIV_BURST_EN
   task automatic test_burst();
      int rises;
      for (int r = 0; r < 2; r++) begin
         enable = 1'b0;
         step();
         checks++; if (burst_done !== 1'b0) begin failures++; $display("FAIL burst_done_clear%0d got=%b exp=0", r, burst_done); end
         load = 1'b1; half_period = 18'd2; burst_len = 8'd3;
         step();
         load = 1'b0; enable = 1'b1;
         rises = 0;
         for (int i = 0; i < 40; i++) begin
            step();
            if (tick_rise === 1'b1) rises++;
         end
         checks++; if (rises != 3) begin failures++; $display("FAIL burst_rises%0d got=%0d exp=3", r, rises); end
         checks++; if (burst_done !== 1'b1 || clk_out !== 1'b0) begin failures++; $display("FAIL burst_end%0d got=%b%b exp=10", r, burst_done, clk_out); end
      end
      enable = 1'b0;
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_default();
      test_reload_mid();
      test_simultaneous();
      test_div2();
      test_disable_reset();
      test_random();
`ifdef CLKDIV_BURST_EN
      test_burst();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
